// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch PC stage with credit-limited fetch buffer and redirect squash
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        JTYPE_FLUSH,
    input  logic [31:0] JTYPE_REAL_ADDR,
    output logic        imem_req_vld,
    input  logic        imem_req_rdy,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_vld,
    input  logic [31:0] imem_rsp_data,
    output logic        if_vld,
    input  logic        id_rdy,
    output logic [31:0] ifPC,
    output logic [31:0] ifInst
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;

    // PC-tag queue: one entry per outstanding fetch, including ones that will be dropped
    logic [31:0]   tag_mem_q [FIFO_DEPTH];
    logic [31:0]   tag_mem_d [FIFO_DEPTH];
    logic [AW:0]   tag_wr_q, tag_wr_d;
    logic [AW:0]   tag_rd_q, tag_rd_d;

    // Fetch buffer: {pc, instruction} pairs waiting for decode
    logic [31:0]   buf_pc_q   [FIFO_DEPTH];
    logic [31:0]   buf_pc_d   [FIFO_DEPTH];
    logic [31:0]   buf_inst_q [FIFO_DEPTH];
    logic [31:0]   buf_inst_d [FIFO_DEPTH];
    logic [AW:0]   buf_wr_q, buf_wr_d;
    logic [AW:0]   buf_rd_q, buf_rd_d;

    logic [CW-1:0] buf_cnt;
    logic [CW:0]   credit_sum;
    logic          accept;
    logic [31:0]   head_pc;
    logic [31:0]   head_inst;

    // Handshake decode and credit check; outstanding fetches plus buffered words never exceed the buffer size
    always_comb begin
        buf_cnt      = buf_wr_q - buf_rd_q;
        credit_sum   = {1'b0, out_q} + {1'b0, buf_cnt};
        imem_req_vld = !rst && !JTYPE_FLUSH && (credit_sum < DEPTH_W);
        imem_req_addr = pc_q;
        accept       = imem_req_vld && imem_req_rdy;
        if_vld       = (buf_cnt != '0);
        head_pc      = buf_pc_q[buf_rd_q[AW-1:0]];
        head_inst    = buf_inst_q[buf_rd_q[AW-1:0]];
        ifPC         = if_vld ? head_pc : 32'h0;
        ifInst       = if_vld ? head_inst : 32'h0;
    end

    // Next-state: request issue, response routing (drop or buffer), decode pop and redirect squash
    always_comb begin
        pc_d       = pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        tag_mem_d  = tag_mem_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;
        buf_wr_d   = buf_wr_q;
        buf_rd_d   = buf_rd_q;

        if (accept) begin
            tag_mem_d[tag_wr_q[AW-1:0]] = pc_q;
            tag_wr_d = tag_wr_q + PTR_ONE;
            pc_d     = pc_q + 32'd4;
        end

        // Every response retires one tag, whether it is kept or dropped
        if (imem_rsp_vld) begin
            tag_rd_d = tag_rd_q + PTR_ONE;
        end
        out_d = out_q + CW'(accept) - CW'(imem_rsp_vld);

        if (JTYPE_FLUSH) begin
            // Redirect wins over push and pop; in-flight fetches become drops
            pc_d     = JTYPE_REAL_ADDR & ~32'h3;
            drop_d   = out_q - CW'(imem_rsp_vld);
            buf_wr_d = '0;
            buf_rd_d = '0;
        end else begin
            if (imem_rsp_vld) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_ONE;
                end else begin
                    buf_pc_d[buf_wr_q[AW-1:0]]   = tag_mem_q[tag_rd_q[AW-1:0]];
                    buf_inst_d[buf_wr_q[AW-1:0]] = imem_rsp_data;
                    buf_wr_d = buf_wr_q + PTR_ONE;
                end
            end
            if (if_vld && id_rdy) begin
                buf_rd_d = buf_rd_q + PTR_ONE;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            out_q    <= '0;
            drop_q   <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            buf_wr_q <= '0;
            buf_rd_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                tag_mem_q[i]  <= '0;
                buf_pc_q[i]   <= '0;
                buf_inst_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            tag_mem_q  <= tag_mem_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            buf_wr_q   <= buf_wr_d;
            buf_rd_q   <= buf_rd_d;
        end
    end

endmodule
